// File: rtl/map_table_if.sv
// Rename-stage bus for map_table: decode-side slots, free_list tags, CDB,
// restore map, and the renamed results returned to dispatch.
interface map_table_if #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int N         = 3
);
    localparam int PREG_BITS = $clog2(PHYS_REGS);
    localparam int AREG_BITS = $clog2(ARCH_REGS);
    localparam int CNT_BITS  = $clog2(N + 1);

    logic [N-1:0]                         rename_valid;
    logic [N-1:0][AREG_BITS-1:0]          dest_areg;
    logic [N-1:0][AREG_BITS-1:0]          src1_areg;
    logic [N-1:0][AREG_BITS-1:0]          src2_areg;
    logic [N-1:0][PREG_BITS-1:0]          alloc_pregs;
    logic [N-1:0]                         alloc_valid;
    logic [N-1:0]                         cdb_valid;
    logic [N-1:0][PREG_BITS-1:0]          cdb_preg;
    logic                                 branch_mispredict;
    logic [ARCH_REGS-1:0][PREG_BITS-1:0]  arch_map_in;

    logic [N-1:0]                         rename_accept;
    logic [CNT_BITS-1:0]                  alloc_count;
    logic [N-1:0][PREG_BITS-1:0]          dest_preg;
    logic [N-1:0][PREG_BITS-1:0]          told_preg;
    logic [N-1:0][PREG_BITS-1:0]          src1_preg;
    logic [N-1:0][PREG_BITS-1:0]          src2_preg;
    logic [N-1:0]                         src1_ready;
    logic [N-1:0]                         src2_ready;

    modport master (
        output rename_valid, dest_areg, src1_areg, src2_areg, alloc_pregs,
               alloc_valid, cdb_valid, cdb_preg, branch_mispredict, arch_map_in,
        input  rename_accept, alloc_count, dest_preg, told_preg,
               src1_preg, src2_preg, src1_ready, src2_ready
    );

    modport slave (
        input  rename_valid, dest_areg, src1_areg, src2_areg, alloc_pregs,
               alloc_valid, cdb_valid, cdb_preg, branch_mispredict, arch_map_in,
        output rename_accept, alloc_count, dest_preg, told_preg,
               src1_preg, src2_preg, src1_ready, src2_ready
    );
endinterface

// File: rtl/map_table.sv
// N-wide R10K rename map table. Outputs are combinational from the current
// map/ready state and the rename group; state updates on the clock edge.
// Optional build macro MAP_TABLE_CDB_BYPASS_EN: a looked-up (non-forwarded)
// source tag matching a same-cycle CDB broadcast reports ready immediately.
module map_table #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int N         = 3
) (
    input logic       clock,
    input logic       reset,
    map_table_if.slave bus
);
    localparam int PREG_BITS = $clog2(PHYS_REGS);
    localparam int AREG_BITS = $clog2(ARCH_REGS);
    localparam int CNT_BITS  = $clog2(N + 1);

    logic [ARCH_REGS-1:0][PREG_BITS-1:0] map_q, map_nx;
    logic [ARCH_REGS-1:0]                rdy_q, rdy_nx;

    logic [N-1:0]                need, acc;
    logic [N-1:0][PREG_BITS-1:0] dpreg, tpreg, s1p, s2p;
    logic [N-1:0]                s1r, s2r;
    logic [CNT_BITS-1:0]         cnt;
    logic                        chain;
    logic [AREG_BITS-1:0]        a_sel;
    logic [PREG_BITS-1:0]        tag;
    logic                        rdy;

    // In-order acceptance; each accepted slot with a destination takes the next free tag.
    always_comb begin
        need  = '0;
        acc   = '0;
        dpreg = '0;
        cnt   = '0;
        chain = !bus.branch_mispredict;
        for (int i = 0; i < N; i++) begin
            need[i] = bus.rename_valid[i] && (bus.dest_areg[i] != '0);
            if (need[i])
                dpreg[i] = bus.alloc_pregs[cnt];
            acc[i] = chain && bus.rename_valid[i] && (!need[i] || bus.alloc_valid[cnt]);
            chain  = acc[i];
            if (acc[i] && need[i])
                cnt = cnt + CNT_BITS'(1);
        end
    end

    // Lookup of T_old (q=0), src1 (q=1) and src2 (q=2), with forwarding from older slots.
    always_comb begin
        tpreg = '0;
        s1p   = '0;
        s2p   = '0;
        s1r   = '0;
        s2r   = '0;
        a_sel = '0;
        tag   = '0;
        rdy   = 1'b0;
        for (int j = 0; j < N; j++) begin
            for (int q = 0; q < 3; q++) begin
                a_sel = (q == 0) ? bus.dest_areg[j] :
                        (q == 1) ? bus.src1_areg[j] : bus.src2_areg[j];
                tag = map_q[a_sel];
                rdy = rdy_q[a_sel];
`ifdef MAP_TABLE_CDB_BYPASS_EN
                // Forwarding below overrides this, so only registered lookups see the bypass.
                for (int c = 0; c < N; c++)
                    if (q != 0 && bus.cdb_valid[c] && bus.cdb_preg[c] == tag)
                        rdy = 1'b1;
`endif
                for (int i = 0; i < j; i++) begin
                    if (acc[i] && need[i] && bus.dest_areg[i] == a_sel) begin
                        tag = dpreg[i];
                        rdy = 1'b0;
                    end
                end
                if (a_sel == '0) begin
                    tag = '0;
                    rdy = 1'b1;
                end
                if (!bus.rename_valid[j]) begin
                    tag = '0;
                    rdy = 1'b0;
                end
                case (q)
                    0:       tpreg[j] = tag;
                    1:       begin s1p[j] = tag; s1r[j] = rdy; end
                    default: begin s2p[j] = tag; s2r[j] = rdy; end
                endcase
            end
        end
    end

    // Next state: CDB wakeups first, then rename writes (youngest last), restore on mispredict.
    always_comb begin
        map_nx = map_q;
        rdy_nx = rdy_q;
        for (int a = 0; a < ARCH_REGS; a++)
            for (int c = 0; c < N; c++)
                if (bus.cdb_valid[c] && bus.cdb_preg[c] == map_q[a])
                    rdy_nx[a] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && need[i]) begin
                map_nx[bus.dest_areg[i]] = dpreg[i];
                rdy_nx[bus.dest_areg[i]] = 1'b0;
            end
        end
        if (bus.branch_mispredict) begin
            map_nx = bus.arch_map_in;
            rdy_nx = '1;
        end
        map_nx[0] = '0;
        rdy_nx[0] = 1'b1;
    end

    // Map and ready registers; reset gives the identity map, all ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < ARCH_REGS; a++)
                map_q[a] <= PREG_BITS'(a);
            rdy_q <= '1;
        end else begin
            map_q <= map_nx;
            rdy_q <= rdy_nx;
        end
    end

    assign bus.rename_accept = acc;
    assign bus.alloc_count   = cnt;
    assign bus.dest_preg     = dpreg;
    assign bus.told_preg     = tpreg;
    assign bus.src1_preg     = s1p;
    assign bus.src2_preg     = s2p;
    assign bus.src1_ready    = s1r;
    assign bus.src2_ready    = s2r;
endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- N-wide R10K rename map table.
- Sits between decode and dispatch. Pulls destination tags from free_list, which is fed by this block's alloc_count.
- Translates architectural source registers to physical tags with ready bits and returns T_old for the ROB.
- Restores from the architectural map on branch mispredict.

Parameters:
ARCH_REGS, 32, number of architectural registers (x0 hardwired)
PHYS_REGS, 64, number of physical registers
N, 3, rename width (instructions per cycle)
PREG_BITS, $clog2(PHYS_REGS), physical tag width (derived, not overridden)
AREG_BITS, $clog2(ARCH_REGS), architectural index width (derived)

Ports:
clock  in  1  system clock, posedge
reset  in  1  asynchronous, active-high reset
rename_valid  in  N  slot i holds a valid instruction (slot 0 oldest)
dest_areg  in  N x AREG_BITS  destination arch reg (0 = no dest)
src1_areg  in  N x AREG_BITS  source 1 arch reg
src2_areg  in  N x AREG_BITS  source 2 arch reg
alloc_pregs  in  N x PREG_BITS  tags offered by free_list, compacted (index 0 first)
alloc_valid  in  N  alloc_pregs[k] is usable
cdb_valid  in  N  completion broadcast valid
cdb_preg  in  N x PREG_BITS  completing tags
branch_mispredict  in  1  flush and restore
arch_map_in  in  ARCH_REGS x PREG_BITS  retirement map used for restore
rename_accept  out  N  slot i renamed this cycle
alloc_count  out  $clog2(N+1)  tags consumed this cycle, to free_list num_tags
dest_preg  out  N x PREG_BITS  new tag for slot i (0 if dest_areg==0)
told_preg  out  N x PREG_BITS  previous mapping of dest_areg
src1_preg, src2_preg  out  N x PREG_BITS  source tags
src1_ready, src2_ready  out  N  source value available

Behaviour:
- State:
  - map[ARCH_REGS] of PREG_BITS.
  - ready[ARCH_REGS] bits, one per map entry.
- Reset (async, any time, including mid-rename): map[a]=a, ready[a]=1 for all a. With no valid slots, all outputs are 0.
- All outputs are combinational from current state and inputs (0-cycle latency). State updates at posedge.
- Slot need: need[i] = rename_valid[i] && dest_areg[i]!=0.
- Tag index: k(i) = number of need[j] with j<i and rename_accept[j].
- Acceptance is in order:
  - rename_accept[i] = rename_valid[i] && (i==0 || rename_accept[i-1]) && (!need[i] || alloc_valid[k(i)]) && !branch_mispredict.
  - A stalled slot blocks all younger slots.
- alloc_count = number of accepted slots with need.
- dest_preg[i] = alloc_pregs[k(i)] when need, else 0.
- Source lookup for slot j reading areg a:
  - If an older accepted slot i<j has need and dest_areg[i]==a, the youngest such i supplies tag = dest_preg[i] and ready = 0 (intra-group forwarding).
  - Otherwise tag = map[a] and ready = ready[a].
  - a==0 always yields tag 0, ready 1.
- told_preg[j]: same forwarding rule applied to dest_areg[j].
- Next state, applied in this order:
  1. CDB: for each valid cdb_preg p, set ready[a]=1 for every a with map[a]==p.
  2. Rename writes: for each accepted slot with need, map[dest]=dest_preg, ready[dest]=0. The youngest slot wins on a duplicate dest. A rename write overrides a CDB set on the same entry.
- branch_mispredict:
  - Same cycle: rename_accept=0 and alloc_count=0.
  - Next state: map=arch_map_in, ready all 1. CDB and rename are ignored.
- Free-list empty (alloc_valid all 0):
  - Only leading slots without need are accepted.
  - State is unchanged except CDB updates.
- map[0] stays 0 and ready[0] stays 1 in all cases.

Optional Feature:
- Macro: MAP_TABLE_CDB_BYPASS_EN.
- Defined: a source whose looked-up tag (not forwarded) matches a valid cdb_preg in the same cycle reports ready=1 combinationally.
- Undefined: ready reflects registered state only, so the value becomes ready one cycle after the broadcast.
- State update is identical either way.

Test Plan:
1. Reset, then read src1_areg=5 in slot 0 -> src1_preg=5, src1_ready=1. All outputs 0 while rename_valid=0.
2. Rename slots 0-2 with dest=3,4,3, alloc_pregs=32,33,34 all valid, slot 2 src1=3 -> slot 2 src1_preg=32 with ready 0, told_preg[2]=32, alloc_count=3. Next cycle map[3]=34, map[4]=33.
3. Rename slots with dest=0,7,8, alloc_valid=1,0,0, alloc_pregs[0]=40 -> accept=3'b011, dest_preg[1]=40, alloc_count=1. Slot 2 is stalled.
4. map[6]=35 not ready; cdb_valid[0]=1 with cdb_preg=35 while slot 0 renames dest=6 with tag 36 -> next cycle map[6]=36, ready[6]=0.
5. CDB broadcast of 35 with a source reading areg 6 (map[6]=35) in the same cycle -> src ready=1 with macro defined, 0 without. Next cycle ready=1 in both builds.
6. Assert branch_mispredict with arch_map_in[a]=a+10 alongside a valid rename group -> rename_accept=0, alloc_count=0. Next cycle src1_areg=2 returns tag 12, ready 1. Pulse reset mid-group -> identity map is restored immediately.
